// File: rtl/car_voltage_adc_sampler.sv
// -----------------------------------------------------------------------------
// car_voltage_adc_sampler
//
// Periodic sampler for the battery-voltage channel of the LTC2308 SPI ADC.
// A free-running period counter fires a frame every SAMPLE_PERIOD clocks (while
// enabled). Each frame pulses CONVST, then clocks 12 SCK periods. During the
// frame the 6-bit config word is sent MSB-first on SDI and 12 result bits are
// captured MSB-first from SDO. The completed word is then presented on data_out
// and held until the next frame completes. data_out feeds the voltage PIO
// in_port, so it only ever changes as a whole word.
//
// Parameters
//   CLK_DIV       clk cycles per SCK half-period (>= 2)
//   CONV_CYCLES   clk cycles CONVST is held high
//   SAMPLE_PERIOD clk cycles between frame starts
//   CFG           LTC2308 config word {S/D, O/S, S1, S0, UNI, SLP}
//
// Ports
//   clk         in   system clock
//   reset_n     in   synchronous active-low reset
//   enable      in   allows new frames to start
//   adc_sdo     in   ADC serial data out
//   adc_convst  out  ADC conversion start
//   adc_sck     out  ADC serial clock
//   adc_sdi     out  ADC serial data in (config word)
//   data_out    out  last completed 12-bit sample
//   data_valid  out  one-cycle pulse when data_out updates
// -----------------------------------------------------------------------------
module car_voltage_adc_sampler #(
    parameter int          CLK_DIV       = 2,
    parameter int          CONV_CYCLES   = 80,
    parameter int          SAMPLE_PERIOD = 50000,
    parameter logic [5:0]  CFG           = 6'b100010
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        adc_sdo,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    output logic [11:0] data_out,
    output logic        data_valid
);

    localparam int PER_W  = $clog2(SAMPLE_PERIOD + 1);
    localparam int CONV_W = $clog2(CONV_CYCLES + 1);
    localparam int DIV_W  = $clog2(CLK_DIV + 1);

    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]        BIT_LAST  = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONV  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [PER_W-1:0]   per_q,    per_d;
    logic [CONV_W-1:0]  conv_q,   conv_d;
    logic [DIV_W-1:0]   div_q,    div_d;
    logic [3:0]         bit_q,    bit_d;
    logic               sck_q,    sck_d;
    logic               sdi_q,    sdi_d;
    logic               convst_q, convst_d;
    logic [11:0]        shreg_q,  shreg_d;
    logic [11:0]        data_q,   data_d;
    logic               valid_q,  valid_d;

    logic               tick;

    // Config bit driven during SCK period idx: CFG MSB-first for bits 0..5,
    // zero for the remaining six periods.
    function automatic logic cfg_bit(input logic [3:0] idx);
        logic [2:0] pos;
        if (idx < 4'd6) begin
            pos = 3'd5 - idx[2:0];
            return CFG[pos];
        end
        return 1'b0;
    endfunction

    // The period counter free-runs regardless of FSM state, so a tick that
    // lands outside IDLE simply skips that frame without shifting the cadence.
    assign tick = (per_q == PER_LAST);

    always_comb begin
        state_d  = state_q;
        per_d    = tick ? '0 : per_q + PER_W'(1);
        conv_d   = conv_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sck_d    = sck_q;
        sdi_d    = sdi_q;
        convst_d = convst_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        valid_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                sck_d    = 1'b0;
                sdi_d    = 1'b0;
                convst_d = 1'b0;
                if (tick && enable) begin
                    state_d  = S_CONV;
                    conv_d   = '0;
                    convst_d = 1'b1;
                end
            end

            S_CONV: begin
                if (conv_q == CONV_LAST) begin
                    // First low phase starts on this edge, so the first config
                    // bit is presented together with it.
                    state_d  = S_SHIFT;
                    convst_d = 1'b0;
                    div_d    = '0;
                    bit_d    = '0;
                    sck_d    = 1'b0;
                    sdi_d    = cfg_bit(4'd0);
                end else begin
                    conv_d = conv_q + CONV_W'(1);
                end
            end

            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sck_q) begin
                        // Rising SCK edge: SDO has been stable through the whole
                        // low phase, so it is captured here directly.
                        sck_d   = 1'b1;
                        shreg_d = {shreg_q[10:0], adc_sdo};
                    end else if (bit_q == BIT_LAST) begin
                        state_d = S_IDLE;
                        sck_d   = 1'b0;
                        sdi_d   = 1'b0;
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        bit_d = bit_q + 4'd1;
                        sck_d = 1'b0;
                        sdi_d = cfg_bit(bit_q + 4'd1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            per_q    <= '0;
            conv_q   <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            sck_q    <= 1'b0;
            sdi_q    <= 1'b0;
            convst_q <= 1'b0;
            shreg_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            per_q    <= per_d;
            conv_q   <= conv_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            sck_q    <= sck_d;
            sdi_q    <= sdi_d;
            convst_q <= convst_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign adc_convst = convst_q;
    assign adc_sck    = sck_q;
    assign adc_sdi    = sdi_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;

endmodule
